// File: rtl/soc_system_gpio_pio_in_if.sv
// Avalon-MM slave bus bundle for the input PIO.
// The master drives address/strobes/data; the slave returns readdata.
interface soc_system_gpio_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_gpio_pio_in.sv
// Input PIO: synchronized input bus, per-bit edge capture (W1C), maskable irq.
// Zero-wait-state Avalon-MM slave on the HPS lightweight bus.
module soc_system_gpio_pio_in #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    soc_system_gpio_pio_in_if.slave  bus,
    input  logic [WIDTH-1:0]         in_port,
    output logic                     irq
);
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int AW      = $clog2(ARM_MAX + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ec_q, ec_d;
    logic [AW-1:0]    arm_q, arm_d;

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] rise, fall, evt, clr;
    logic             armed, wr;
    logic             unused_wdata;

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign rise         = sync_out & ~prev_q;
    assign fall         = ~sync_out & prev_q;
    assign armed        = (arm_q == AW'(ARM_MAX));
    assign wr           = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        evt = rise | fall;
        if (EDGE_TYPE == 0) begin
            evt = rise;
        end else if (EDGE_TYPE == 1) begin
            evt = fall;
        end
    end

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d = sync_out;
        arm_d  = armed ? arm_q : arm_q + 1'b1;
        mask_d = mask_q;
        clr    = '0;
        if (wr && bus.address == 2'd2) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr && bus.address == 2'd3) begin
            clr = bus.writedata[WIDTH-1:0];
        end
        // A new event overrides a same-cycle clear of that bit.
        ec_d = (ec_q & ~clr) | (armed ? evt : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
            mask_q <= '0;
            ec_q   <= '0;
            arm_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            mask_q <= mask_d;
            ec_q   <= ec_d;
            arm_q  <= arm_d;
        end
    end

    assign irq = |(ec_q & mask_q);

    always_comb begin
        unique case (bus.address)
            2'd0:    bus.readdata = 32'(sync_out);
            2'd2:    bus.readdata = 32'(mask_q);
            2'd3:    bus.readdata = 32'(ec_q);
            default: bus.readdata = '0;
        endcase
    end
endmodule
